// File: rtl/fir_out_pkg.sv
// Shared definitions for the FIR output buffer: default widths, FSM state
// encoding and the scale/round/saturate helper used on every captured result.
package fir_out_pkg;

    localparam int DEF_IN_W  = 18;
    localparam int DEF_OUT_W = 16;
    localparam int DEF_SHIFT = 2;
    localparam int DEF_DEPTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Right-shift by 'shift' (optionally round-half-up first), then clamp to out_w bits.
    // One extra bit of headroom keeps the rounding carry from wrapping.
    function automatic logic [31:0] sat_round(input logic [31:0] val,
                                              input int          shift,
                                              input int          out_w,
                                              input logic        round_en);
        logic [32:0] acc;
        logic [32:0] top;
        acc = {1'b0, val};
        if (round_en && shift > 0) begin
            acc = acc + (33'd1 << (shift - 1));
        end
        acc = acc >> shift;
        top = (33'd1 << out_w) - 33'd1;
        if (acc > top) begin
            acc = top;
        end
        return acc[31:0];
    endfunction

endpackage

// File: rtl/fir_out_buffer_if.sv
// Sink-side valid/ready stream carrying scaled FIR samples.
interface fir_out_buffer_if #(
    parameter int OUT_W = 16
) ();
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/fir_out_fifo.sv
// Synchronous show-ahead FIFO. The head is presented whenever the FIFO is
// non-empty (forced to zero when empty). A push into a full FIFO is accepted
// only if a pop frees a slot in the same cycle; otherwise it is reported as a drop.
module fir_out_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     rd_ready,
    output logic [W-1:0]             rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     drop
);
    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]    CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0]  PTR_ONE  = AW'(1);

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic          full;
    logic          pop;
    logic          wr_en;

    assign rd_valid = (cnt_q != '0);
    assign rd_data  = rd_valid ? mem_q[rptr_q] : '0;
    assign level    = cnt_q;

    // Decide push/pop acceptance and next pointer/count values.
    always_comb begin
        full   = (cnt_q == CNT_FULL);
        pop    = rd_valid && rd_ready;
        wr_en  = push && (!full || pop);
        drop   = push && full && !pop;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (wr_en) wptr_d = wptr_q + PTR_ONE;
        if (pop)   rptr_d = rptr_q + PTR_ONE;
        case ({wr_en, pop})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage array; contents need no reset because the head is gated by rd_valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr_q] <= push_data;
    end

endmodule

// File: rtl/fir_out_buffer.sv
// FIR output buffer: captures FIR results on fir_done while running, scales and
// saturates them in one register stage, then queues them for a valid/ready sink.
// Optional build macro FIR_OUT_ROUND_EN selects round-half-up instead of truncation.
module fir_out_buffer
    import fir_out_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int SHIFT = DEF_SHIFT,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [IN_W-1:0]         fir_data,
    input  logic                    fir_done,
    fir_out_buffer_if.master        sink,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow,
    output logic                    busy
);
`ifdef FIR_OUT_ROUND_EN
    localparam logic ROUND_EN = 1'b1;
`else
    localparam logic ROUND_EN = 1'b0;
`endif

    state_e                  state_q, state_d;
    logic                    accept;
    logic                    vld_p1_q, vld_p1_d;
    logic [OUT_W-1:0]        scl_p1_q, scl_p1_d;
    logic                    overflow_q, overflow_d;
    logic                    fifo_drop;
    logic [$clog2(DEPTH):0]  fifo_level;

    // FSM next state plus busy/accept decode; drain ends once queue and stage are empty.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        accept  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_RUN;
            end
            ST_RUN: begin
                accept = 1'b1;
                if (!enable) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (enable) begin
                    state_d = ST_RUN;
                end else if (fifo_level == '0 && !vld_p1_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy = (state_q != ST_IDLE);
    end

    // Scale stage input and sticky overflow update.
    always_comb begin
        vld_p1_d   = fir_done && accept;
        scl_p1_d   = scl_p1_q;
        if (vld_p1_d) begin
            scl_p1_d = OUT_W'(sat_round(32'(fir_data), SHIFT, OUT_W, ROUND_EN));
        end
        overflow_d = overflow_q || fifo_drop;
    end

    // Control registers: FSM, stage valid, overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            vld_p1_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            vld_p1_q   <= vld_p1_d;
            overflow_q <= overflow_d;
        end
    end

    // Scale stage data register (qualified by vld_p1_q, so no reset).
    always_ff @(posedge clk) begin
        scl_p1_q <= scl_p1_d;
    end

    fir_out_fifo #(
        .W     (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (vld_p1_q),
        .push_data (scl_p1_q),
        .rd_ready  (sink.out_ready),
        .rd_data   (sink.out_data),
        .rd_valid  (sink.out_valid),
        .level     (fifo_level),
        .drop      (fifo_drop)
    );

    assign level    = fifo_level;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_fir_out_buffer.sv
// Bench for fir_out_buffer; honours FIR_OUT_ROUND_EN in its reference model.
module tb_fir_out_buffer;

    localparam int DEPTH = 8;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [17:0] fir_data;
    logic        fir_done;
    logic [3:0]  level;
    logic        overflow;
    logic        busy;

    int tests = 0;
    int fails = 0;

    // reference model state
    int q[$];
    bit m_stg;
    int m_stg_val;
    int m_mode;
    bit m_ovf;

    fir_out_buffer_if #(.OUT_W(16)) bus ();

    fir_out_buffer dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .fir_data (fir_data),
        .fir_done (fir_done),
        .sink     (bus),
        .level    (level),
        .overflow (overflow),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic int scale(input int x);
        int s;
`ifdef FIR_OUT_ROUND_EN
        s = (x + 2) / 4;
`else
        s = x / 4;
`endif
        if (s > 65535) s = 65535;
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int old_size;
        bit old_stg;
        int old_val;
        bit pop;
        if (rst) begin
            q.delete();
            m_stg  = 1'b0;
            m_mode = M_IDLE;
            m_ovf  = 1'b0;
            return;
        end
        old_size = q.size();
        old_stg  = m_stg;
        old_val  = m_stg_val;
        pop = (old_size > 0) && bus.out_ready;
        if (pop) void'(q.pop_front());
        if (old_stg) begin
            if (old_size < DEPTH || pop) q.push_back(old_val);
            else m_ovf = 1'b1;
        end
        m_stg     = fir_done && (m_mode == M_RUN);
        m_stg_val = scale(int'(fir_data));
        case (m_mode)
            M_IDLE:  if (enable) m_mode = M_RUN;
            M_RUN:   if (!enable) m_mode = M_DRAIN;
            default: begin
                if (enable) m_mode = M_RUN;
                else if (old_size == 0 && !old_stg) m_mode = M_IDLE;
            end
        endcase
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
        check("out_data",  32'(bus.out_data),  32'(q.size() > 0 ? q[0] : 0));
        check("level",     32'(level),         32'(q.size()));
        check("overflow",  32'(overflow),      32'(m_ovf));
        check("busy",      32'(busy),          32'(m_mode != M_IDLE));
    endtask

    task automatic strobe(input logic [17:0] d);
        fir_data = d;
        fir_done = 1'b1;
        cyc();
        fir_done = 1'b0;
    endtask

    function automatic logic [17:0] rnd18();
        return 18'($urandom_range(0, 32'h3FFFF));
    endfunction

    initial begin
        logic [17:0] seq3 [3];
        seq3[0] = 18'd4; seq3[1] = 18'd5; seq3[2] = 18'd6;
        rst = 1'b1; enable = 1'b0; fir_data = '0; fir_done = 1'b0; bus.out_ready = 1'b0;
        m_stg = 1'b0; m_stg_val = 0; m_mode = M_IDLE; m_ovf = 1'b0;
        cyc(); cyc();

        // 1: small values, sink always ready
        rst = 1'b0; enable = 1'b1; bus.out_ready = 1'b1;
        cyc();
        for (int i = 0; i < 3; i++) begin
            strobe(seq3[i]);
            cyc(); cyc();
        end
        strobe(18'd7);
        cyc(); cyc();

        // 2: top code saturates / truncates to 16'hFFFF
        strobe(18'h3FFFF);
        cyc();
        check("sat_data", 32'(bus.out_data), 32'h0000FFFF);
        cyc(); cyc();

        // 3: sink stalled, nine strobes into eight entries
        rst = 1'b1; cyc(); rst = 1'b0;
        bus.out_ready = 1'b0;
        cyc();
        for (int i = 0; i < 9; i++) strobe(rnd18());
        cyc(); cyc();
        check("full_level", 32'(level), 32'd8);
        check("full_ovf",   32'(overflow), 32'd1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) cyc();
        check("drained_level", 32'(level), 32'd0);

        // 4: full FIFO, pop and push on the same edge
        rst = 1'b1; cyc(); rst = 1'b0;
        bus.out_ready = 1'b0;
        cyc();
        for (int i = 0; i < 8; i++) strobe(rnd18());
        cyc(); cyc();
        strobe(rnd18());
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;
        check("pp_level", 32'(level), 32'd8);
        check("pp_ovf",   32'(overflow), 32'd0);
        cyc();

        // 5: enable drops with five queued, later strobes ignored
        bus.out_ready = 1'b1;
        cyc(); cyc(); cyc();
        bus.out_ready = 1'b0;
        check("pre_drain_level", 32'(level), 32'd5);
        enable = 1'b0;
        cyc();
        check("drain_busy", 32'(busy), 32'd1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            fir_data = rnd18();
            fir_done = 1'b1;
            cyc();
        end
        fir_done = 1'b0;
        check("idle_busy",  32'(busy), 32'd0);
        check("idle_level", 32'(level), 32'd0);

        // 6: reset with level 4, overflow set, and a strobe in flight
        enable = 1'b1; bus.out_ready = 1'b0;
        cyc();
        for (int i = 0; i < 9; i++) strobe(rnd18());
        cyc(); cyc();
        bus.out_ready = 1'b1;
        cyc(); cyc(); cyc(); cyc();
        bus.out_ready = 1'b0;
        check("pre_rst_level", 32'(level), 32'd4);
        check("pre_rst_ovf",   32'(overflow), 32'd1);
        strobe(rnd18());
        rst = 1'b1;
        cyc();
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_ovf",   32'(overflow), 32'd0);
        rst = 1'b0;
        cyc(); cyc();
        check("post_rst_level", 32'(level), 32'd0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            rst           = ($urandom_range(0, 149) == 0);
            enable        = ($urandom_range(0, 9) != 0);
            fir_done      = 1'($urandom_range(0, 1));
            fir_data      = rnd18();
            bus.out_ready = ($urandom_range(0, 2) != 0);
            cyc();
        end
        rst = 1'b0; fir_done = 1'b0; enable = 1'b0; bus.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
